// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment page scheduler.
//   NUM_DIGITS / BCD_W / DIG_W : display geometry
//   MAX_VAL                    : largest value representable on four digits
//   conv_state_e               : shared converter state encoding
//   page_e                     : displayed page encoding
//   lzb_mask()                 : leading-zero blank mask (rightmost digit never blanked)
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned DIG_W      = NUM_DIGITS * BCD_W;
    localparam int unsigned MAX_VAL    = 9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

    typedef enum logic {
        PAGE_TEMP = 1'b0,
        PAGE_SETP = 1'b1
    } page_e;

    // Mark every zero digit left of the first non-zero digit; digit 0 always shown.
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [DIG_W-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  lead;
        m    = '0;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (lead && (d[i*BCD_W +: BCD_W] == 4'd0)) begin
                m[i] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : load bin and begin (ignored bits above 9999 must be clamped by caller)
//   bin        : binary input, VAL_W bits
//   bcd        : BCD result, valid when done pulses and held afterwards
//   done       : one-cycle pulse, high the cycle after the last shift
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int unsigned VAL_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic [DIG_W-1:0] bcd,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] bin_q;
    logic [DIG_W-1:0] bcd_q;
    logic [DIG_W-1:0] adj_c;
    logic [CNT_W-1:0] cnt;
    logic             active;

    // Add 3 to every BCD digit >= 5 before the shift.
    always_comb begin
        adj_c = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5) begin
                adj_c[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
    end

    // Shift register: VAL_W shifts after start, then a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin_q  <= bin;
                bcd_q  <= '0;
                cnt    <= '0;
                active <= 1'b1;
            end else if (active) begin
                bcd_q <= {adj_c[DIG_W-2:0], bin_q[VAL_W-1]};
                bin_q <= {bin_q[VAL_W-2:0], 1'b0};
                cnt   <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(VAL_W - 1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/seg_page_scheduler.sv
// Two-source page scheduler for a four-digit seven-segment scan driver.
// Temperature and setpoint arrive over valid/ready, queue in holding registers,
// and share one sequential BCD converter (round-robin on ties). The shown page
// alternates every DWELL_CYCLES unless hold_page freezes it.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   temp_val/vld/rdy     : temperature handshake
//   setp_val/vld/rdy     : setpoint handshake
//   hold_page            : freeze dwell timer and page
//   digits, blank        : BCD digits ([15:12] leftmost) and blank mask (bit3 leftmost)
//   page                 : 0 temperature, 1 setpoint
//   busy                 : converter not idle
// Build option: define SEG_LZB_EN to enable leading-zero blanking.
module seg_page_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned VAL_W        = 14,
    parameter int unsigned DWELL_CYCLES = 200_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VAL_W-1:0]      temp_val,
    input  logic                  temp_vld,
    output logic                  temp_rdy,
    input  logic [VAL_W-1:0]      setp_val,
    input  logic                  setp_vld,
    output logic                  setp_rdy,
    input  logic                  hold_page,
    output logic [DIG_W-1:0]      digits,
    output logic [NUM_DIGITS-1:0] blank,
    output logic                  page,
    output logic                  busy
);

    localparam int unsigned TMR_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DWELL_CYCLES - 1);

`ifdef SEG_LZB_EN
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = 4'b1110;
`else
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = 4'b0000;
`endif

    conv_state_e           state, state_nxt;
    logic                  pend_t, pend_s, pend_t_nxt, pend_s_nxt;
    logic [VAL_W-1:0]      hold_t, hold_s;
    logic                  prio_setp, cur_setp;
    logic                  start_c, sel_setp_c, wr_c;
    logic [VAL_W-1:0]      conv_in_c;
    logic [DIG_W-1:0]      conv_bcd, result_t, result_s, disp_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  conv_done;
    logic [TMR_W-1:0]      timer;

    function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v);
        if (32'(v) > MAX_VAL) begin
            return VAL_W'(MAX_VAL);
        end
        return v;
    endfunction

    // Converter sequencing, arbitration and holding-register occupancy.
    always_comb begin
        state_nxt  = state;
        start_c    = 1'b0;
        wr_c       = 1'b0;
        sel_setp_c = (pend_t && pend_s) ? prio_setp : pend_s;
        conv_in_c  = clamp_val(sel_setp_c ? hold_s : hold_t);

        case (state)
            // DONE arbitrates like IDLE so back-to-back requests run without a gap.
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (pend_t || pend_s) begin
                    start_c   = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (conv_done) begin
                    wr_c      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase

        pend_t_nxt = pend_t;
        if (start_c && !sel_setp_c) begin
            pend_t_nxt = 1'b0;
        end else if (temp_vld && temp_rdy) begin
            pend_t_nxt = 1'b1;
        end

        pend_s_nxt = pend_s;
        if (start_c && sel_setp_c) begin
            pend_s_nxt = 1'b0;
        end else if (setp_vld && setp_rdy) begin
            pend_s_nxt = 1'b1;
        end

        disp_c = (page_e'(page) == PAGE_SETP) ? result_s : result_t;
`ifdef SEG_LZB_EN
        blank_c = lzb_mask(disp_c);
`else
        blank_c = '0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake, arbitration pointer and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_t    <= 1'b0;
            pend_s    <= 1'b0;
            temp_rdy  <= 1'b1;
            setp_rdy  <= 1'b1;
            hold_t    <= '0;
            hold_s    <= '0;
            prio_setp <= 1'b0;
            cur_setp  <= 1'b0;
            result_t  <= '0;
            result_s  <= '0;
            busy      <= 1'b0;
        end else begin
            pend_t   <= pend_t_nxt;
            pend_s   <= pend_s_nxt;
            temp_rdy <= ~pend_t_nxt;
            setp_rdy <= ~pend_s_nxt;
            busy     <= (state_nxt != ST_IDLE);
            if (temp_vld && temp_rdy) begin
                hold_t <= temp_val;
            end
            if (setp_vld && setp_rdy) begin
                hold_s <= setp_val;
            end
            if (start_c) begin
                cur_setp  <= sel_setp_c;
                prio_setp <= ~sel_setp_c;
            end
            if (wr_c) begin
                if (cur_setp) begin
                    result_s <= conv_bcd;
                end else begin
                    result_t <= conv_bcd;
                end
            end
        end
    end

    // Dwell timer and page; output registers follow the page one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer  <= '0;
            page   <= 1'b0;
            digits <= '0;
            blank  <= BLANK_RST;
        end else begin
            if (!hold_page) begin
                if (timer == TMR_LAST) begin
                    timer <= '0;
                    page  <= ~page;
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end
            digits <= disp_c;
            blank  <= blank_c;
        end
    end

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .bin   (conv_in_c),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

endmodule

// File: tb/tb_seg_page_scheduler.sv
// Directed bench for seg_page_scheduler: table of single conversions plus
// hand-written sequences for latency, arbitration, reset abort and page hold.
module tb_seg_page_scheduler;

    localparam int unsigned VAL_W = 14;
    localparam int unsigned DWELL = 40;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [VAL_W-1:0] temp_val = '0;
    logic             temp_vld = 1'b0;
    logic             temp_rdy;
    logic [VAL_W-1:0] setp_val = '0;
    logic             setp_vld = 1'b0;
    logic             setp_rdy;
    logic             hold_page = 1'b1;
    logic [15:0]      digits;
    logic [3:0]       blank;
    logic             page;
    logic             busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [VAL_W-1:0] val;
        logic [15:0]      exp_digits;
        logic [3:0]       exp_blank_lzb;
    } vec_t;

    vec_t vecs[10];

    seg_page_scheduler #(
        .VAL_W        (VAL_W),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .temp_val  (temp_val),
        .temp_vld  (temp_vld),
        .temp_rdy  (temp_rdy),
        .setp_val  (setp_val),
        .setp_vld  (setp_vld),
        .setp_rdy  (setp_rdy),
        .hold_page (hold_page),
        .digits    (digits),
        .blank     (blank),
        .page      (page),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [3:0] exp_blank(input logic [3:0] lzb);
`ifdef SEG_LZB_EN
        return lzb;
`else
        return 4'b0000 & lzb;
`endif
    endfunction

    task automatic do_reset(input logic hold);
        reset     = 1'b1;
        hold_page = hold;
        temp_vld  = 1'b0;
        setp_vld  = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{14'd7,     16'h0007, 4'b1110};
        vecs[1] = '{14'd0,     16'h0000, 4'b1110};
        vecs[2] = '{14'd1050,  16'h1050, 4'b0000};
        vecs[3] = '{14'd12000, 16'h9999, 4'b0000};
        vecs[4] = '{14'd99,    16'h0099, 4'b1100};
        vecs[5] = '{14'd9999,  16'h9999, 4'b0000};
        vecs[6] = '{14'd10000, 16'h9999, 4'b0000};
        vecs[7] = '{14'd5,     16'h0005, 4'b1110};
        vecs[8] = '{14'd16383, 16'h9999, 4'b0000};
        vecs[9] = '{14'd273,   16'h0273, 4'b1000};

        // Reset state
        do_reset(1'b1);
        check("rst_digits", 32'(digits), 32'h0000);
        check("rst_blank", 32'(blank), 32'(exp_blank(4'b1110)));
        check("rst_page", 32'(page), 0);
        check("rst_temp_rdy", 32'(temp_rdy), 1);
        check("rst_setp_rdy", 32'(setp_rdy), 1);
        check("rst_busy", 32'(busy), 0);

        // Single conversion latency: 273
        temp_val = 14'd273;
        temp_vld = 1'b1;
        step(1);
        temp_vld = 1'b0;
        check("lat_rdy_e0", 32'(temp_rdy), 0);
        check("lat_busy_e0", 32'(busy), 0);
        step(1);
        check("lat_rdy_e1", 32'(temp_rdy), 1);
        check("lat_busy_e1", 32'(busy), 1);
        for (int e = 2; e <= 16; e++) begin
            step(1);
            check($sformatf("lat_busy_e%0d", e), 32'(busy), 1);
        end
        check("lat_digits_e16", 32'(digits), 32'h0000);
        step(1);
        check("lat_digits_e17", 32'(digits), 32'h0273);
        check("lat_busy_e17", 32'(busy), 0);

        // Table of conversions on the temperature page
        for (int i = 0; i < 10; i++) begin
            temp_val = vecs[i].val;
            temp_vld = 1'b1;
            step(1);
            temp_vld = 1'b0;
            step(17);
            check($sformatf("vec%0d_digits", i), 32'(digits), 32'(vecs[i].exp_digits));
            check($sformatf("vec%0d_blank", i), 32'(blank), 32'(exp_blank(vecs[i].exp_blank_lzb)));
            check($sformatf("vec%0d_busy", i), 32'(busy), 0);
        end

        // Reset in the middle of a conversion of 4321
        do_reset(1'b1);
        temp_val = 14'd4321;
        temp_vld = 1'b1;
        step(1);
        temp_vld = 1'b0;
        step(7);
        check("abort_busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_digits", 32'(digits), 32'h0000);
        check("abort_rdy", 32'(temp_rdy), 1);
        step(2);
        reset = 1'b0;
        step(20);
        check("abort_digits_later", 32'(digits), 32'h0000);
        check("abort_busy_later", 32'(busy), 0);

        // Simultaneous requests and page toggle
        do_reset(1'b0);
        temp_val = 14'd25;
        setp_val = 14'd30;
        temp_vld = 1'b1;
        setp_vld = 1'b1;
        step(1);
        temp_vld = 1'b0;
        setp_vld = 1'b0;
        check("both_trdy_e0", 32'(temp_rdy), 0);
        check("both_srdy_e0", 32'(setp_rdy), 0);
        step(1);
        check("both_trdy_e1", 32'(temp_rdy), 1);
        check("both_srdy_e1", 32'(setp_rdy), 0);
        step(16);
        check("both_digits_e17", 32'(digits), 32'h0025);
        check("both_srdy_e17", 32'(setp_rdy), 1);
        check("both_busy_e17", 32'(busy), 1);
        step(15);
        check("both_busy_e32", 32'(busy), 1);
        step(1);
        check("both_busy_e33", 32'(busy), 0);
        step(5);
        check("both_page_e38", 32'(page), 0);
        step(1);
        check("both_page_e39", 32'(page), 1);
        check("both_digits_e39", 32'(digits), 32'h0025);
        step(1);
        check("both_digits_e40", 32'(digits), 32'h0030);
        check("both_blank_e40", 32'(blank), 32'(exp_blank(4'b1100)));

        // hold_page freezes timer and page
        do_reset(1'b1);
        for (int k = 1; k <= 3; k++) begin
            step(DWELL);
            check($sformatf("hold_page_%0d", k), 32'(page), 0);
        end
        hold_page = 1'b0;
        step(DWELL - 1);
        check("release_page_before", 32'(page), 0);
        step(1);
        check("release_page_after", 32'(page), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
